// File: rtl/base_acredit_snk_vc_if.sv
// Bus bundle for the multi-channel credit sink: the tagged input beat, per-channel
// valid/ready outputs and the credit-return message.
`timescale 1ns/1ps
interface base_acredit_snk_vc_if #(
  parameter int channels     = 2,
  parameter int credits      = 8,
  parameter int width        = 8,
  parameter int log_channels = (channels > 1) ? $clog2(channels) : 1,
  parameter int log_credits  = $clog2(credits)
);
  logic                      i_v;
  logic [log_channels-1:0]   i_ch;
  logic [width-1:0]          i_d;
  logic [channels-1:0]       o_v;
  logic [channels-1:0]       o_r;
  logic [channels*width-1:0] o_d;
  logic                      i_c_v;
  logic [log_channels-1:0]   i_c_ch;
  logic [log_credits:0]      i_c_n;

  // Upstream/consumer side drives beats and readies.
  modport master (
    output i_v, i_ch, i_d, o_r,
    input  o_v, o_d, i_c_v, i_c_ch, i_c_n
  );

  // Sink side.
  modport slave (
    input  i_v, i_ch, i_d, o_r,
    output o_v, o_d, i_c_v, i_c_ch, i_c_n
  );
endinterface

// File: rtl/base_acredit_snk_vc.sv
// Multi-channel credit sink. Each channel owns a FIFO of `credits` entries built as a
// registered head (o_d comes straight from a flop) backed by a small memory. Freed
// credits accumulate per channel and are returned as coalesced, round-robin messages.
`timescale 1ns/1ps
module base_acredit_snk_vc #(
  parameter int channels     = 2,
  parameter int credits      = 8,
  parameter int width        = 8,
  parameter int log_channels = (channels > 1) ? $clog2(channels) : 1,
  parameter int log_credits  = $clog2(credits)
) (
  input  logic                 clk,
  input  logic                 reset,
  base_acredit_snk_vc_if.slave bus,
  output logic                 err
);

  // Memory address width, kept at least 1 so credits=1 still elaborates.
  localparam int aw = (credits > 1) ? $clog2(credits) : 1;
  // Occupancy/credit count width, holds 0..credits.
  localparam int cw = log_credits + 1;

  logic                    ch_ok;
  logic [channels-1:0]     sel, full, wr, pop;
  logic [channels-1:0]     ram_we, ram_re;

  logic [channels-1:0]     out_v_q, out_v_d;
  logic [width-1:0]        out_d_q   [channels];
  logic [width-1:0]        out_d_d   [channels];
  logic [aw-1:0]           wr_ptr_q  [channels];
  logic [aw-1:0]           wr_ptr_d  [channels];
  logic [aw-1:0]           rd_ptr_q  [channels];
  logic [aw-1:0]           rd_ptr_d  [channels];
  logic [cw-1:0]           ram_cnt_q [channels];
  logic [cw-1:0]           ram_cnt_d [channels];
  logic [width-1:0]        ram_q     [channels][credits];

  logic [cw-1:0]           pend_q    [channels];
  logic [cw-1:0]           pend_d    [channels];
  logic [channels-1:0]     gnt;
  logic                    gnt_any;
  logic [log_channels-1:0] gnt_ch;
  logic [log_channels-1:0] last_q, last_d;

  logic                    c_v_q;
  logic [log_channels-1:0] c_ch_q;
  logic [cw-1:0]           c_n_q;
  logic                    err_q, err_d;

  function automatic logic [aw-1:0] ptr_inc(input logic [aw-1:0] p);
    return (p == aw'(credits - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ch_ok = (int'(bus.i_ch) < channels);

  // Per-channel write select, fullness (head flop plus memory) and pop.
  always_comb begin
    sel  = '0;
    full = '0;
    wr   = '0;
    pop  = '0;
    for (int c = 0; c < channels; c++) begin
      sel[c]  = bus.i_v && ch_ok && (bus.i_ch == log_channels'(c));
      full[c] = ((cw'(out_v_q[c]) + ram_cnt_q[c]) == cw'(credits));
      // A pop in the same cycle does not free room for a write: that is still overflow.
      wr[c]   = sel[c] && !full[c];
      pop[c]  = out_v_q[c] && bus.o_r[c];
    end
  end

  // FIFO next state: refill the head from memory first, else bypass the new beat.
  always_comb begin
    for (int c = 0; c < channels; c++) begin
      out_v_d[c]   = out_v_q[c];
      out_d_d[c]   = out_d_q[c];
      wr_ptr_d[c]  = wr_ptr_q[c];
      rd_ptr_d[c]  = rd_ptr_q[c];
      ram_cnt_d[c] = ram_cnt_q[c];
      ram_we[c]    = 1'b0;
      ram_re[c]    = 1'b0;
      if (!out_v_q[c] || pop[c]) begin
        if (ram_cnt_q[c] != '0) begin
          out_v_d[c] = 1'b1;
          out_d_d[c] = ram_q[c][rd_ptr_q[c]];
          ram_re[c]  = 1'b1;
        end else if (wr[c]) begin
          out_v_d[c] = 1'b1;
          out_d_d[c] = bus.i_d;
        end else begin
          out_v_d[c] = 1'b0;
        end
      end
      // The beat goes to memory unless it was bypassed straight into the head.
      ram_we[c] = wr[c] && ((out_v_q[c] && !pop[c]) || (ram_cnt_q[c] != '0));
      if (ram_we[c]) wr_ptr_d[c] = ptr_inc(wr_ptr_q[c]);
      if (ram_re[c]) rd_ptr_d[c] = ptr_inc(rd_ptr_q[c]);
      ram_cnt_d[c] = ram_cnt_q[c] + cw'(ram_we[c]) - cw'(ram_re[c]);
    end
  end

  // Beat storage; contents are meaningless until counted in, so no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < channels; c++) begin
      if (ram_we[c]) ram_q[c][wr_ptr_q[c]] <= bus.i_d;
    end
  end

  // Round-robin credit arbiter starting after the last grant; pend absorbs grant and pop.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_ch  = last_q;
    gnt     = '0;
    for (int k = 1; k <= channels; k++) begin
      idx = (int'(last_q) + k) % channels;
      if (!gnt_any && (pend_q[idx] != '0)) begin
        gnt_any = 1'b1;
        gnt_ch  = log_channels'(idx);
      end
    end
    for (int c = 0; c < channels; c++) begin
      gnt[c]    = gnt_any && (gnt_ch == log_channels'(c));
      pend_d[c] = (gnt[c] ? '0 : pend_q[c]) + cw'(pop[c]);
    end
    last_d = gnt_any ? gnt_ch : last_q;
  end

  // Error is sticky: bad channel or write into a full FIFO.
  always_comb begin
    err_d = err_q | (bus.i_v && (!ch_ok || ((sel & full) != '0)));
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v_q <= '0;
      for (int c = 0; c < channels; c++) begin
        out_d_q[c]   <= '0;
        wr_ptr_q[c]  <= '0;
        rd_ptr_q[c]  <= '0;
        ram_cnt_q[c] <= '0;
        pend_q[c]    <= '0;
      end
      last_q <= log_channels'(channels - 1);
      c_v_q  <= 1'b0;
      c_ch_q <= '0;
      c_n_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      out_v_q <= out_v_d;
      for (int c = 0; c < channels; c++) begin
        out_d_q[c]   <= out_d_d[c];
        wr_ptr_q[c]  <= wr_ptr_d[c];
        rd_ptr_q[c]  <= rd_ptr_d[c];
        ram_cnt_q[c] <= ram_cnt_d[c];
        pend_q[c]    <= pend_d[c];
      end
      last_q <= last_d;
      c_v_q  <= gnt_any;
      if (gnt_any) begin
        c_ch_q <= gnt_ch;
        c_n_q  <= pend_q[gnt_ch];
      end
      err_q <= err_d;
    end
  end

  // Pending credits can never exceed the FIFO depth; if they do, accounting is broken.
  always_ff @(posedge clk) begin
    for (int c = 0; c < channels; c++) begin
      if (reset && !gnt[c]) assert (int'(pend_q[c]) + int'(pop[c]) <= credits);
    end
  end

  // Drive the bus outputs from registers.
  always_comb begin
    bus.o_d = '0;
    for (int c = 0; c < channels; c++) begin
      bus.o_d[c*width +: width] = out_d_q[c];
    end
  end

  assign bus.o_v    = out_v_q;
  assign bus.i_c_v  = c_v_q;
  assign bus.i_c_ch = c_ch_q;
  assign bus.i_c_n  = c_n_q;
  assign err        = err_q;

endmodule
